// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
// Holds the frame-state encoding and the default link timing constants.
package uart_pkg;

    // 50 MHz clk_sys, 9600 baud, 16x oversampling
    localparam int UART_TICK_DIV   = 326;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Counter width for a counter wrapping at n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick divider, shared by both ends of the link.
// tick is high for the single clk in which the divider sits at TICK_DIV-1.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int TICK_DIV = UART_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]   TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt;

    // Divider counts 0..TICK_DIV-1 and wraps; it never resynchronises to frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == TERM) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = (div_cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with start/busy handshake; also sources the shared
// oversampling tick. Define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for tx_start
// ST_START  | line low; waits for first tick, then OVERSAMPLE ticks
// ST_DATA   | line = shift[0], LSB first, OVERSAMPLE ticks per bit
// ST_PARITY | line = even parity of the latched byte (parity build only)
// ST_STOP   | line high for OVERSAMPLE ticks; last tick ends the frame
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICK_DIV   = UART_TICK_DIV,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tick
);

    localparam int               TCW       = cnt_width(OVERSAMPLE);
    localparam int               BCW       = cnt_width(DATA_BITS + 1);
    localparam logic [TCW-1:0]   TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0]   BIT_LAST  = BCW'(DATA_BITS - 1);

    uart_state_e          state;
    uart_state_e          state_nxt;
    logic [TCW-1:0]       tick_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 aligned;
    logic                 accept;
    logic                 bit_end;

    uart_baud_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Only IDLE accepts; the frame-end cycle is still STOP, so a request there is dropped
    assign accept  = (state == ST_IDLE) && tx_start;
    assign bit_end = tick && aligned && (tick_cnt == TICK_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit timing, bit index and shift register. The first tick after accept only
    // aligns the start bit to the divider, so the start bit is never shorter than
    // a full bit; a tick landing in the accept cycle itself already counts as aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            aligned  <= 1'b0;
        end else if (accept) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= din;
            aligned  <= tick;
        end else if ((state != ST_IDLE) && tick) begin
            if (!aligned) begin
                aligned <= 1'b1;
            end else if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (state == ST_DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BCW'(1);
                end
            end else begin
                tick_cnt <= tick_cnt + TCW'(1);
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    // Even parity captured with the byte so later din changes cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^din;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; busy drops together with the done pulse in the last stop-bit clk
    always_comb begin
        tx      = 1'b1;
        tx_busy = (state != ST_IDLE);
        tx_done = 1'b0;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_bit;
`endif
            ST_STOP: begin
                tx = 1'b1;
                if (bit_end) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a small divider (TICK_DIV=4).
// A line monitor decodes each frame and compares it against a queue of
// bytes expected from the stimulus side.
module tb_uart_tx;

    localparam int TD   = 4;
    localparam int OS   = 16;
    localparam int NB   = 8;
    localparam int BITC = TD * OS;
`ifdef UART_TX_PARITY_EN
    localparam int AFTER_START = NB + 2;
`else
    localparam int AFTER_START = NB + 1;
`endif

    logic          clk;
    logic          rst;
    logic [NB-1:0] din;
    logic          tx_start;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;
    logic          tick;

    int            n_checks;
    int            n_errors;
    int            done_cnt;
    int            frames_seen;
    bit            mon_en;
    logic [NB-1:0] exp_q[$];

    uart_tx #(
        .TICK_DIV   (TD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .tx_start (tx_start),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && tx_done) done_cnt++;
    end

    // Line monitor: decode each frame at mid-bit, measure its length via tx_done
    initial begin
        logic [NB-1:0] data;
        logic [NB-1:0] exp_byte;
        int            k;
        int            start_len;
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx === 1'b0) begin
                k    = 0;
                data = '0;
                for (int i = 0; i < NB; i++) begin
                    while (k < BITC * (i + 1) + BITC / 2) begin
                        @(negedge clk);
                        k++;
                    end
                    data[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                while (k < BITC * (NB + 1) + BITC / 2) begin
                    @(negedge clk);
                    k++;
                end
                chk("parity_bit", {31'd0, tx}, {31'd0, ^data});
`endif
                while (k < BITC * AFTER_START + BITC / 2) begin
                    @(negedge clk);
                    k++;
                end
                chk("stop_bit", {31'd0, tx}, 32'd1);
                while (!tx_done && k < BITC * (AFTER_START + 2)) begin
                    @(negedge clk);
                    k++;
                end
                chk("done_seen", {31'd0, tx_done}, 32'd1);
                chk("busy_at_done", {31'd0, tx_busy}, 32'd0);
                start_len = k + 1 - BITC * AFTER_START;
                chk("start_len_ok", {31'd0, (start_len >= BITC && start_len <= BITC + TD - 1)}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    exp_byte = exp_q.pop_front();
                    chk("frame_data", {24'd0, data}, {24'd0, exp_byte});
                end
                frames_seen++;
            end
        end
    end

    task automatic pulse_start(input logic [NB-1:0] b, input bit expect_accept);
        @(negedge clk);
        din      = b;
        tx_start = 1'b1;
        if (expect_accept) exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n;
        n = 0;
        while (frames_seen < target && n < BITC * 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, frames_seen, target);
    endtask

    initial begin
        int  d0;
        int  n;
        bit  tx_low;
        n_checks    = 0;
        n_errors    = 0;
        done_cnt    = 0;
        frames_seen = 0;
        mon_en      = 1'b0;
        rst         = 1'b0;
        din         = '0;
        tx_start    = 1'b0;

        // Reset values
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset mid-frame aborts immediately
        pulse_start(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        chk("pre_abort_busy", {31'd0, tx_busy}, 32'd1);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, tx_busy}, 32'd0);
        chk("abort_done", {31'd0, tx_done}, 32'd0);
        chk("abort_tick", {31'd0, tick}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 2 * TD; i++) begin
            @(negedge clk);
            chk("tick_after_rst", {31'd0, tick}, {31'd0, (i % TD) == TD - 1});
        end
        tx_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        chk("abort_no_done", done_cnt, d0);
        chk("abort_line_idle", {31'd0, tx_low}, 32'd0);

        mon_en = 1'b1;

        // Single byte; din changed after accept and a busy-time request must be ignored
        d0 = done_cnt;
        pulse_start(8'h55, 1'b1);
        din = 8'h00;
        chk("busy_after_accept", {31'd0, tx_busy}, 32'd1);
        repeat (300) @(negedge clk);
        pulse_start(8'hFF, 1'b0);
        wait_frames(1, "frames_single");
        repeat (BITC * 12) @(negedge clk);
        chk("single_frames_total", frames_seen, 1);
        chk("single_done_pulses", done_cnt - d0, 1);
        chk("single_idle_busy", {31'd0, tx_busy}, 32'd0);

        // Back-to-back with tx_start held high: exactly one idle clk between frames
        d0 = done_cnt;
        @(negedge clk);
        din      = 8'h00;
        tx_start = 1'b1;
        exp_q.push_back(8'h00);
        n = 0;
        while (!tx_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        din = 8'hFF;
        exp_q.push_back(8'hFF);
        n = 0;
        while (!tx_done && n < BITC * 14) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done", {31'd0, tx_done}, 32'd1);
        @(negedge clk);
        chk("b2b_gap_tx", {31'd0, tx}, 32'd1);
        chk("b2b_gap_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        chk("b2b_second_start", {31'd0, tx}, 32'd0);
        chk("b2b_second_busy", {31'd0, tx_busy}, 32'd1);
        tx_start = 1'b0;
        wait_frames(3, "frames_b2b");
        repeat (BITC * 12) @(negedge clk);
        chk("b2b_done_pulses", done_cnt - d0, 2);

        // Parity-sensitive patterns (even parity 0 and 1 in the parity build)
        pulse_start(8'hA5, 1'b1);
        wait_frames(4, "frames_a5");
        pulse_start(8'h07, 1'b1);
        wait_frames(5, "frames_07");
        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
